arvi_bus_mem: RTL and testbench
===============================

# arvi_bus_mem

Single-port word memory that acts as the responder on the arvi core's native data/instruction bus, answering the core's `bus_en`/`wr_en`/`byte_en` requests with an `ack` pulse and read data. It replaces the free-running random `ack`/`rdata` drivers in simulation and synthesis tops, with a programmable, deterministic wait-state count, so the core can run real programs. It sits directly on the core's bus port with no interconnect between them.

## Interface
- `DEPTH_WORDS`, 1024: memory depth in 32-bit words; must be a power of two, ≥ 4.
- `WAIT_CYCLES`, 1: wait states inserted between request capture and `o_ack`; range 0–15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*4`.
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst` in 1: reset, asynchronous and active-high.
- `i_bus_en` in 1: request valid; held by the core until it sees `o_ack`.
- `i_wr_en` in 1: 1 = write, 0 = read; qualified by `i_bus_en`.
- `i_addr` in 32: byte address; bits [1:0] are ignored.
- `i_wr_data` in 32: write data, little-endian byte lanes.
- `i_byte_en` in 4: write byte lanes; bit n enables `i_wr_data[8n+7:8n]`.
- `o_ack` out 1: one-cycle completion pulse.
- `o_rd_data` out 32: read data, valid only while `o_ack` = 1.
- `o_err` out 1: present only with `ARVI_BUS_MEM_ERR_EN`; error flag valid with `o_ack`.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - With `i_bus_en` = 1 at the edge, latch `i_addr`, `i_wr_en`, `i_wr_data` and `i_byte_en`.
  - Go to WAIT if `WAIT_CYCLES` > 0, otherwise go to ACK.
- WAIT:
  - A 4-bit counter loads `WAIT_CYCLES-1` on entry and decrements each cycle.
  - Go to ACK on the edge where the counter is 0.
  - `i_bus_en` and the bus fields are ignored in this state, because the latched copies are used.
- Entering ACK, same edge:
  - Write: update the enabled lanes of the addressed word.
  - Read: register the full word into `o_rd_data`. `i_byte_en` is ignored on reads.
- ACK: `o_ack` = 1 for exactly one cycle, then go to IDLE. `i_bus_en` is not sampled in the ACK cycle.
- Word index = (latched addr − `BASE_ADDR`) >> 2. It is in range when the index is below `DEPTH_WORDS`.
- Out-of-range access:
  - Write is dropped.
  - Read returns 32'h0.
  - `o_ack` is still issued, so the core never hangs.
- A write with `i_byte_en` = 4'b0000 is acked and changes nothing.
- Back-to-back requests: if `i_bus_en` is still high in the IDLE cycle after the ack, it is a new request.

## Timing
- Reset values:
  - FSM = IDLE.
  - `o_ack` = 0.
  - `o_rd_data` = 32'h0.
  - `o_err` = 0.
  - Wait counter = 0.
  - Memory array is not reset; its contents are retained across reset.
- Latency: with `i_bus_en` sampled high at the end of cycle N, `o_ack` = 1 in cycle N+1+`WAIT_CYCLES`.
- Throughput: one transaction every `WAIT_CYCLES`+2 cycles (capture cycle, `WAIT_CYCLES` wait cycles, ACK cycle).
- `o_rd_data` holds its value after the ack until the next read completes. The core must not rely on this.
- Reset asserted in WAIT or ACK:
  - The transaction is aborted and FSM goes to IDLE asynchronously.
  - A pending write is not performed if reset arrives before the ACK-entry edge.
  - `o_ack` drops immediately.
- Read-after-write to the same word, back to back: the read returns the newly written data.

## Configuration
- `ARVI_BUS_MEM_ERR_EN` defined:
  - Adds port `o_err`.
  - `o_err` = 1 in the ACK cycle when the access is out of range, or when the access is a write with `i_addr[1:0]` ≠ 0.
  - Such erroneous writes are dropped.
- Undefined:
  - No `o_err` port.
  - Out-of-range access behaves as described in Operation.
  - Misaligned writes use the word at `i_addr[31:2]`.

## Test plan
- Reset, then write 32'hDEADBEEF with `byte_en` 4'hF to addr 0x10, then read 0x10 -> `o_ack` in cycle N+2 (`WAIT_CYCLES`=1) for each access; read returns 32'hDEADBEEF.
- Write 32'h0000_AA00 with `byte_en` 4'b0010 over 32'h11223344 at addr 0x20, then read 0x20 -> 32'h1122AA44.
- `WAIT_CYCLES`=0 with `i_bus_en` held high for 6 cycles of reads -> `o_ack` pulses every 2 cycles, each exactly 1 cycle wide.
- Read addr `BASE_ADDR`+`DEPTH_WORDS`*4 -> `o_ack` with data 32'h0; with `ARVI_BUS_MEM_ERR_EN`, `o_err` = 1 in the same cycle. A write to a misaligned addr 0x22 with the macro -> `o_err` = 1 and memory unchanged.
- `WAIT_CYCLES`=3: issue a write of 32'h55 to 0x40, pulse `i_rst` during WAIT -> no `o_ack`. A subsequent read of 0x40 returns the prior contents, not 32'h55.
- Write 0x30 then immediately read 0x30 with `i_bus_en` held continuously -> read returns the written value, and no request is dropped or duplicated.

Source files
------------

// File: rtl/arvi_bus_mem_if.sv
// arvi_bus_mem_if: native arvi data/instruction bus between the core (master)
// and a memory responder (slave).
//   i_bus_en  : request valid, held until o_ack
//   i_wr_en   : 1 = write, 0 = read
//   i_addr    : byte address, bits [1:0] ignored for word selection
//   i_wr_data : write data, little-endian byte lanes
//   i_byte_en : write lane enables
//   o_ack     : one-cycle completion pulse
//   o_rd_data : read data, valid with o_ack
//   o_err     : error flag valid with o_ack (only with ARVI_BUS_MEM_ERR_EN)
// Optional feature macro: ARVI_BUS_MEM_ERR_EN adds o_err.
interface arvi_bus_mem_if;
  logic        i_bus_en;
  logic        i_wr_en;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic [3:0]  i_byte_en;
  logic        o_ack;
  logic [31:0] o_rd_data;
`ifdef ARVI_BUS_MEM_ERR_EN
  logic        o_err;

  modport master (output i_bus_en, i_wr_en, i_addr, i_wr_data, i_byte_en,
                  input  o_ack, o_rd_data, o_err);
  modport slave  (input  i_bus_en, i_wr_en, i_addr, i_wr_data, i_byte_en,
                  output o_ack, o_rd_data, o_err);
`else
  modport master (output i_bus_en, i_wr_en, i_addr, i_wr_data, i_byte_en,
                  input  o_ack, o_rd_data);
  modport slave  (input  i_bus_en, i_wr_en, i_addr, i_wr_data, i_byte_en,
                  output o_ack, o_rd_data);
`endif
endinterface

// File: rtl/arvi_bus_mem.sv
// arvi_bus_mem: single-port word memory answering the arvi core bus with a
// fixed, programmable number of wait states before each o_ack pulse.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : arvi_bus_mem_if.slave (request in, ack/read data/error out)
// Parameters:
//   DEPTH_WORDS : memory depth in 32-bit words (power of two, >= 4)
//   WAIT_CYCLES : wait states between request capture and o_ack (0..15)
//   BASE_ADDR   : byte address of word 0, aligned to DEPTH_WORDS*4
// Optional feature macro: ARVI_BUS_MEM_ERR_EN drives o_err for out-of-range
// accesses and misaligned writes, and drops such writes.
//
// state  | meaning
// IDLE   | waiting for i_bus_en; request fields captured on the accepting edge
// WAIT   | counting wait states on the latched request
// ACK    | o_ack high for one cycle; memory access done on the entry edge
module arvi_bus_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic           i_clk,
  input logic           i_rst,
  arvi_bus_mem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wr_data_q;
  logic [3:0]  byte_en_q;
  logic [31:0] rd_data_q;
  logic        err_q;

  logic        capture;
  logic        ack_entry;
  logic        acc_wr;
  logic [31:0] acc_addr;
  logic [31:0] acc_wr_data;
  logic [3:0]  acc_byte_en;
  logic [29:0] off_w;
  logic        in_range;
  logic [AW-1:0] idx;
  logic        acc_err;
  logic        drop_wr;
  logic        do_write;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_bus_en) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ack_entry = (state_d == S_ACK) && (state_q != S_ACK);

  // With zero wait states the ACK-entry edge is the capture edge itself, so
  // the access has to use the live bus fields instead of the latched copies.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_wr      = bus.i_wr_en;
      acc_addr    = bus.i_addr;
      acc_wr_data = bus.i_wr_data;
      acc_byte_en = bus.i_byte_en;
    end else begin
      acc_wr      = wr_q;
      acc_addr    = addr_q;
      acc_wr_data = wr_data_q;
      acc_byte_en = byte_en_q;
    end
  end

  // Word offset from the base; addresses below BASE_ADDR wrap to large
  // offsets and fall out of range.
  assign off_w    = acc_addr[31:2] - BASE_ADDR[31:2];
  assign in_range = (off_w[29:AW] == '0);
  assign idx      = off_w[AW-1:0];

`ifdef ARVI_BUS_MEM_ERR_EN
  assign acc_err = !in_range || (acc_wr && (acc_addr[1:0] != 2'b00));
  assign drop_wr = acc_err;
  assign bus.o_err = err_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^acc_addr[1:0];
  assign acc_err = !in_range;
  assign drop_wr = !in_range;
`endif

  // Reset must also suppress a write whose ACK entry coincides with reset.
  assign do_write = ack_entry && acc_wr && !drop_wr && !i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 32'h0;
      wr_data_q <= 32'h0;
      byte_en_q <= 4'h0;
      rd_data_q <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        wr_q      <= bus.i_wr_en;
        addr_q    <= bus.i_addr;
        wr_data_q <= bus.i_wr_data;
        byte_en_q <= bus.i_byte_en;
      end
      if (ack_entry && !acc_wr) begin
        rd_data_q <= in_range ? mem[idx] : 32'h0;
      end
      err_q <= ack_entry ? acc_err : 1'b0;
    end
  end

  // Storage is deliberately not reset so contents survive a bus reset.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_byte_en[b]) begin
          mem[idx][8*b +: 8] <= acc_wr_data[8*b +: 8];
        end
      end
    end
  end

  assign bus.o_ack     = (state_q == S_ACK);
  assign bus.o_rd_data = rd_data_q;

endmodule

// File: tb/tb_arvi_bus_mem.sv
module tb_arvi_bus_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd1;
  logic        bus_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  be = 4'h0;

  logic        ack_m;
  logic [31:0] rd_m;
  logic        err_m;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  arvi_bus_mem_if if0 ();
  arvi_bus_mem_if if1 ();
  arvi_bus_mem_if if3 ();

  assign if0.i_bus_en = bus_en & (sel == 2'd0);
  assign if1.i_bus_en = bus_en & (sel == 2'd1);
  assign if3.i_bus_en = bus_en & (sel == 2'd3);
  assign if0.i_wr_en = wr_en;  assign if1.i_wr_en = wr_en;  assign if3.i_wr_en = wr_en;
  assign if0.i_addr  = addr;   assign if1.i_addr  = addr;   assign if3.i_addr  = addr;
  assign if0.i_wr_data = wdata; assign if1.i_wr_data = wdata; assign if3.i_wr_data = wdata;
  assign if0.i_byte_en = be;   assign if1.i_byte_en = be;   assign if3.i_byte_en = be;

  arvi_bus_mem #(.WAIT_CYCLES(0)) u_dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
  arvi_bus_mem #(.WAIT_CYCLES(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
  arvi_bus_mem #(.WAIT_CYCLES(3)) u_dut3 (.i_clk(clk), .i_rst(rst), .bus(if3));

  always_comb begin
    ack_m = if1.o_ack;
    rd_m  = if1.o_rd_data;
    if (sel == 2'd0) begin
      ack_m = if0.o_ack;
      rd_m  = if0.o_rd_data;
    end else if (sel == 2'd3) begin
      ack_m = if3.o_ack;
      rd_m  = if3.o_rd_data;
    end
  end

`ifdef ARVI_BUS_MEM_ERR_EN
  always_comb begin
    err_m = if1.o_err;
    if (sel == 2'd0) err_m = if0.o_err;
    else if (sel == 2'd3) err_m = if3.o_err;
  end
`else
  assign err_m = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drives one request at a falling edge and waits (bounded) for the ack.
  // lat counts falling edges from drive to ack; 0 means no ack arrived.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int lat, output logic [31:0] rd,
                        output logic er);
    @(negedge clk);
    bus_en = 1'b1; wr_en = w; addr = a; wdata = d; be = b;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack_m) begin
        lat = i;
        break;
      end
    end
    rd = rd_m;
    er = err_m;
    bus_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [15:0] pat;

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,       32'h0000AA00, 4'h2, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,       32'h0,        4'hF, 32'h1122AA44, 1'b0};
    vecs[5]  = '{1'b1, 32'h24,       32'h01020304, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'h24,       32'hCAFEF00D, 4'h0, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h24,       32'h0,        4'h0, 32'h01020304, 1'b0};
    vecs[8]  = '{1'b0, 32'h1000,     32'h0,        4'h0, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'h0,        32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 32'h1000,     32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h0,        32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
`ifdef ARVI_BUS_MEM_ERR_EN
    vecs[12] = '{1'b1, 32'h22,       32'hFFFF0000, 4'hF, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h1122AA44, 1'b0};
`else
    vecs[12] = '{1'b1, 32'h22,       32'hFFFF0000, 4'hF, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h20,       32'h0,        4'h0, 32'hFFFF0000, 1'b0};
`endif
    vecs[14] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};

    // Reset state of all three instances.
    repeat (3) @(negedge clk);
    chk("rst_ack0", {31'h0, if0.o_ack}, 32'h0);
    chk("rst_ack1", {31'h0, if1.o_ack}, 32'h0);
    chk("rst_ack3", {31'h0, if3.o_ack}, 32'h0);
    chk("rst_rd1",  if1.o_rd_data, 32'h0);
    rst = 1'b0;

    // Table-driven accesses on the one-wait-state instance.
    sel = 2'd1;
    for (int i = 0; i < 15; i++) begin
      access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, rd, er);
      chk($sformatf("vec%0d_lat", i), lat, 2);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
`ifdef ARVI_BUS_MEM_ERR_EN
      chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
`endif
      @(negedge clk);
      chk($sformatf("vec%0d_ackw", i), {31'h0, ack_m}, 32'h0);
    end

    // Zero wait states: write then read of 0x30 with bus_en held throughout.
    sel = 2'd0;
    @(negedge clk);
    bus_en = 1'b1; wr_en = 1'b1; addr = 32'h30; wdata = 32'h600DF00D; be = 4'hF;
    pat = '0;
    rd = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat[k] = ack_m;
      if (ack_m && wr_en) begin
        wr_en = 1'b0;
      end else if (ack_m) begin
        rd = rd_m;
        bus_en = 1'b0;
      end
    end
    chk("raw_ackpat", {24'h0, pat[7:0]}, 32'h0000_0005);
    chk("raw_rd", rd, 32'h600DF00D);

    // Zero wait states: continuous reads ack every other cycle.
    @(negedge clk);
    bus_en = 1'b1; wr_en = 1'b0; addr = 32'h30;
    pat = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      pat[k] = ack_m;
    end
    bus_en = 1'b0;
    chk("b2b_ackpat", {20'h0, pat[11:0]}, 32'h0000_0555);
    chk("b2b_rd", rd_m, 32'h600DF00D);

    // Three wait states: reset during WAIT aborts a pending write.
    sel = 2'd3;
    access(1'b1, 32'h40, 32'h0BADCAFE, 4'hF, lat, rd, er);
    chk("w3_lat", lat, 4);
    @(negedge clk);
    bus_en = 1'b1; wr_en = 1'b1; addr = 32'h40; wdata = 32'h55; be = 4'hF;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 bus_en = 1'b0;
    chk("w3_rst_ack", {31'h0, ack_m}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pat[k] = ack_m;
    end
    chk("w3_noack", {26'h0, pat[5:0]}, 32'h0);
    access(1'b0, 32'h40, 32'h0, 4'h0, lat, rd, er);
    chk("w3_rd_lat", lat, 4);
    chk("w3_rd", rd, 32'h0BADCAFE);

    // Reset in the ACK cycle drops o_ack at once.
    access(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    chk("ackrst_pre", {31'h0, ack_m}, 32'h1);
    #1 rst = 1'b1;
    #1 chk("ackrst_drop", {31'h0, ack_m}, 32'h0);
    chk("ackrst_rd", rd_m, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Memory contents survive reset.
    sel = 2'd1;
    access(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    chk("retain_lat", lat, 2);
    chk("retain_rd", rd, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
